// File: rtl/wiz_bus_ctrl.sv
// Avalon-MM slave to W5300 parallel-bus bridge with programmable setup/strobe/hold timing.
// Optional feature macro: WIZ_INT_SYNC_EN (2-flop synchronizer on WIZ_INT_N before irq).
module wiz_bus_ctrl #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        avs_chipselect,
    input  logic [9:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    input  logic [1:0]  avs_byteenable,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [9:0]  WIZ_A,
    output logic [15:0] WIZ_D_OUT,
    output logic        WIZ_D_OE,
    input  logic [15:0] WIZ_D_IN,
    output logic        WIZ_CS_N,
    output logic        WIZ_RD_N,
    output logic        WIZ_WR_N,
    input  logic        WIZ_INT_N,
    output logic        irq
);

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_is_write;

    logic        w_req;
    logic        w_req_write;
    logic        w_skip;
    logic        w_accept;
    logic        w_dir_next;
    logic        w_active_next;
    logic        w_read_capture;

    logic        r_cs_n;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_d_oe;
    logic [9:0]  r_a;
    logic [15:0] r_d_out;
    logic [15:0] r_readdata;
    logic        r_waitrequest;

    // A simultaneous read+write is treated as a write.
    assign w_req       = avs_chipselect & (avs_read | avs_write);
    assign w_req_write = avs_write;
    assign w_skip      = (avs_byteenable != 2'b11);
    assign w_accept    = (r_state == ST_IDLE) && w_req;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_skip) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_SETUP;
                        w_cnt_next = SETUP_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_next     = ST_STROBE;
                    w_cnt_next = STROBE_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_next     = ST_HOLD;
                    w_cnt_next = HOLD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_next     = ST_DONE;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // Chip-side outputs are registered from the next state so they line up with r_state.
    assign w_dir_next     = w_accept ? w_req_write : r_is_write;
    assign w_active_next  = (w_next == ST_SETUP) || (w_next == ST_STROBE) || (w_next == ST_HOLD);
    assign w_read_capture = (r_state == ST_STROBE) && (r_cnt == 4'd0) && !r_is_write;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_is_write    <= 1'b0;
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_d_oe        <= 1'b0;
            r_a           <= 10'd0;
            r_d_out       <= 16'd0;
            r_readdata    <= 16'd0;
            r_waitrequest <= 1'b1;
        end else begin
            r_cs_n        <= !w_active_next;
            r_rd_n        <= !((w_next == ST_STROBE) && !w_dir_next);
            r_wr_n        <= !((w_next == ST_STROBE) && w_dir_next);
            r_d_oe        <= w_active_next && w_dir_next;
            r_waitrequest <= (w_next != ST_DONE);
            if (w_accept) begin
                r_is_write <= w_req_write;
                if (w_skip) begin
                    r_readdata <= 16'd0;
                end else begin
                    r_a     <= avs_address;
                    r_d_out <= avs_writedata;
                end
            end
            if (w_read_capture) begin
                r_readdata <= WIZ_D_IN;
            end
        end
    end

    assign WIZ_CS_N        = r_cs_n;
    assign WIZ_RD_N        = r_rd_n;
    assign WIZ_WR_N        = r_wr_n;
    assign WIZ_D_OE        = r_d_oe;
    assign WIZ_A           = r_a;
    assign WIZ_D_OUT       = r_d_out;
    assign avs_readdata    = r_readdata;
    assign avs_waitrequest = r_waitrequest;

`ifdef WIZ_INT_SYNC_EN
    // The second synchronizer stage stores the inverted level, so it doubles as the irq register.
    logic r_int_meta;
    logic r_irq;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_int_meta <= 1'b1;
            r_irq      <= 1'b0;
        end else begin
            r_int_meta <= WIZ_INT_N;
            r_irq      <= !r_int_meta;
        end
    end

    assign irq = r_irq;
`else
    assign irq = !WIZ_INT_N;
`endif

endmodule

// File: tb/tb_wiz_bus_ctrl.sv
// Scoreboard-based bench for wiz_bus_ctrl: default-timing instance plus a SETUP=2/STROBE=1/HOLD=2 instance.
module tb_wiz_bus_ctrl;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic [15:0] dIn = 16'd0;
    logic intN = 1'b1;

    logic cs0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [9:0] addr0 = 10'd0;
    logic [15:0] wdata0 = 16'd0;
    logic [1:0] be0 = 2'b11;
    logic [15:0] rdata0;
    logic wait0, oe0, csN0, rdN0, wrN0, irq0;
    logic [9:0] wa0;
    logic [15:0] dout0;

    logic cs1 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [9:0] addr1 = 10'd0;
    logic [15:0] wdata1 = 16'd0;
    logic [1:0] be1 = 2'b11;
    logic [15:0] rdata1;
    logic wait1, oe1, csN1, rdN1, wrN1, irq1;
    logic [9:0] wa1;
    logic [15:0] dout1;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        int          latency;
        int          csLow;
        int          wrLow;
        int          rdLow;
        bit          chkRdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    wiz_bus_ctrl dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .avs_chipselect(cs0), .avs_address(addr0), .avs_read(rd0), .avs_write(wr0),
        .avs_writedata(wdata0), .avs_byteenable(be0),
        .avs_readdata(rdata0), .avs_waitrequest(wait0),
        .WIZ_A(wa0), .WIZ_D_OUT(dout0), .WIZ_D_OE(oe0), .WIZ_D_IN(dIn),
        .WIZ_CS_N(csN0), .WIZ_RD_N(rdN0), .WIZ_WR_N(wrN0),
        .WIZ_INT_N(intN), .irq(irq0)
    );

    wiz_bus_ctrl #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2)) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .avs_chipselect(cs1), .avs_address(addr1), .avs_read(rd1), .avs_write(wr1),
        .avs_writedata(wdata1), .avs_byteenable(be1),
        .avs_readdata(rdata1), .avs_waitrequest(wait1),
        .WIZ_A(wa1), .WIZ_D_OUT(dout1), .WIZ_D_OE(oe1), .WIZ_D_IN(dIn),
        .WIZ_CS_N(csN1), .WIZ_RD_N(rdN1), .WIZ_WR_N(wrN1),
        .WIZ_INT_N(intN), .irq(irq1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one Avalon transfer and measures the chip-side activity; returns doneCyc=-1 on timeout.
    task automatic runXfer(input int dut, input logic rd, input logic wr, input logic [9:0] addr,
                           input logic [15:0] data, input logic [1:0] be,
                           output int doneCyc, output int csLow, output int wrLow, output int rdLow,
                           output int bothLow, output int busBad, output logic [15:0] rdAtDone);
        logic oCs, oRd, oWr, oOe, oWait;
        logic [9:0] oA;
        logic [15:0] oDout, oRdata;
        bit isWrite;
        isWrite = wr;
        doneCyc = -1; csLow = 0; wrLow = 0; rdLow = 0; bothLow = 0; busBad = 0; rdAtDone = 16'hxxxx;
        if (dut == 0) begin
            cs0 = 1'b1; rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data; be0 = be;
        end else begin
            cs1 = 1'b1; rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = data; be1 = be;
        end
        for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
            tick();
            if (dut == 0) begin
                oCs = csN0; oRd = rdN0; oWr = wrN0; oOe = oe0; oWait = wait0; oA = wa0; oDout = dout0; oRdata = rdata0;
            end else begin
                oCs = csN1; oRd = rdN1; oWr = wrN1; oOe = oe1; oWait = wait1; oA = wa1; oDout = dout1; oRdata = rdata1;
            end
            if (!oCs) csLow++;
            if (!oWr) wrLow++;
            if (!oRd) rdLow++;
            if (!oRd && !oWr) bothLow++;
            if (!oCs && (oA !== addr || oOe !== isWrite || (isWrite && oDout !== data))) busBad++;
            if (oCs && (oOe !== 1'b0 || oRd !== 1'b1 || oWr !== 1'b1)) busBad++;
            if (oWait === 1'b0) begin
                doneCyc = c;
                rdAtDone = oRdata;
            end
        end
        if (dut == 0) begin
            cs0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        end else begin
            cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        intN = 1'b1;
        tick();
        tick();
        nVectors++; if (csN0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_cs_n: got %b expected 1", csN0); end
        nVectors++; if (rdN0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_rd_n: got %b expected 1", rdN0); end
        nVectors++; if (wrN0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_wr_n: got %b expected 1", wrN0); end
        nVectors++; if (oe0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_d_oe: got %b expected 0", oe0); end
        nVectors++; if (wa0 !== 10'd0) begin nMiscompares++; $display("[TB] FAIL reset_addr: got %h expected 000", wa0); end
        nVectors++; if (dout0 !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_d_out: got %h expected 0000", dout0); end
        nVectors++; if (rdata0 !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_readdata: got %h expected 0000", rdata0); end
        nVectors++; if (wait0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_waitrequest: got %b expected 1", wait0); end
        nVectors++; if (irq0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_irq: got %b expected 0", irq0); end
        nVectors++; if (wait1 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_waitrequest_dut1: got %b expected 1", wait1); end
        RST_N = 1'b1;
        tick();
        nVectors++; if (wait0 !== 1'b1 || csN0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL idle_quiet: got wait=%b cs_n=%b expected 1 1", wait0, csN0); end
    endtask

    // Pops the scoreboard entry pushed by the calling test and compares it to the measurement.
    task automatic test_write();
        int d, cl, wl, rl, bl, bb;
        logic [15:0] rdv;
        exp_t e;
        sb.push_back('{latency: 6, csLow: 5, wrLow: 3, rdLow: 0, chkRdata: 0, rdata: 16'h0});
        runXfer(0, 1'b0, 1'b1, 10'h200, 16'hA55A, 2'b11, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency) begin nMiscompares++; $display("[TB] FAIL write_latency: got %0d expected %0d", d, e.latency); end
        nVectors++; if (cl != e.csLow) begin nMiscompares++; $display("[TB] FAIL write_cs_low: got %0d expected %0d", cl, e.csLow); end
        nVectors++; if (wl != e.wrLow) begin nMiscompares++; $display("[TB] FAIL write_wr_low: got %0d expected %0d", wl, e.wrLow); end
        nVectors++; if (rl != e.rdLow) begin nMiscompares++; $display("[TB] FAIL write_rd_low: got %0d expected %0d", rl, e.rdLow); end
        nVectors++; if (bb != 0) begin nMiscompares++; $display("[TB] FAIL write_bus: got %0d bad cycles expected 0", bb); end
        nVectors++; if (bl != 0) begin nMiscompares++; $display("[TB] FAIL write_both_low: got %0d expected 0", bl); end
    endtask

    task automatic test_read();
        int d, cl, wl, rl, bl, bb;
        logic [15:0] rdv;
        exp_t e;
        dIn = 16'h1234;
        sb.push_back('{latency: 6, csLow: 5, wrLow: 0, rdLow: 3, chkRdata: 1, rdata: 16'h1234});
        runXfer(0, 1'b1, 1'b0, 10'h004, 16'h0000, 2'b11, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency) begin nMiscompares++; $display("[TB] FAIL read_latency: got %0d expected %0d", d, e.latency); end
        nVectors++; if (cl != e.csLow) begin nMiscompares++; $display("[TB] FAIL read_cs_low: got %0d expected %0d", cl, e.csLow); end
        nVectors++; if (rl != e.rdLow) begin nMiscompares++; $display("[TB] FAIL read_rd_low: got %0d expected %0d", rl, e.rdLow); end
        nVectors++; if (wl != e.wrLow) begin nMiscompares++; $display("[TB] FAIL read_wr_low: got %0d expected %0d", wl, e.wrLow); end
        nVectors++; if (bb != 0) begin nMiscompares++; $display("[TB] FAIL read_bus: got %0d bad cycles expected 0", bb); end
        nVectors++; if (e.chkRdata && rdv !== e.rdata) begin nMiscompares++; $display("[TB] FAIL read_data: got %h expected %h", rdv, e.rdata); end
    endtask

    task automatic test_skip();
        int d, cl, wl, rl, bl, bb;
        logic [15:0] rdv;
        exp_t e;
        sb.push_back('{latency: 1, csLow: 0, wrLow: 0, rdLow: 0, chkRdata: 0, rdata: 16'h0});
        runXfer(0, 1'b0, 1'b1, 10'h155, 16'hFFFF, 2'b01, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency) begin nMiscompares++; $display("[TB] FAIL skip_wr_latency: got %0d expected %0d", d, e.latency); end
        nVectors++; if (cl != e.csLow || wl != e.wrLow) begin nMiscompares++; $display("[TB] FAIL skip_wr_strobes: got cs=%0d wr=%0d expected 0 0", cl, wl); end
        dIn = 16'h5A5A;
        sb.push_back('{latency: 1, csLow: 0, wrLow: 0, rdLow: 0, chkRdata: 1, rdata: 16'h0000});
        runXfer(0, 1'b1, 1'b0, 10'h004, 16'h0000, 2'b10, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency) begin nMiscompares++; $display("[TB] FAIL skip_rd_latency: got %0d expected %0d", d, e.latency); end
        nVectors++; if (cl != e.csLow || rl != e.rdLow) begin nMiscompares++; $display("[TB] FAIL skip_rd_strobes: got cs=%0d rd=%0d expected 0 0", cl, rl); end
        nVectors++; if (rdv !== e.rdata) begin nMiscompares++; $display("[TB] FAIL skip_rd_data: got %h expected %h", rdv, e.rdata); end
    endtask

    task automatic test_custom_timing();
        int d, cl, wl, rl, bl, bb;
        logic [15:0] rdv;
        exp_t e;
        sb.push_back('{latency: 6, csLow: 5, wrLow: 1, rdLow: 0, chkRdata: 0, rdata: 16'h0});
        runXfer(1, 1'b1, 1'b1, 10'h3C1, 16'h0FF0, 2'b11, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency) begin nMiscompares++; $display("[TB] FAIL rw_latency: got %0d expected %0d", d, e.latency); end
        nVectors++; if (wl != e.wrLow || rl != e.rdLow) begin nMiscompares++; $display("[TB] FAIL rw_is_write: got wr=%0d rd=%0d expected %0d %0d", wl, rl, e.wrLow, e.rdLow); end
        nVectors++; if (cl != e.csLow || bb != 0) begin nMiscompares++; $display("[TB] FAIL rw_bus: got cs=%0d bad=%0d expected %0d 0", cl, bb, e.csLow); end
        dIn = 16'h8421;
        sb.push_back('{latency: 6, csLow: 5, wrLow: 0, rdLow: 1, chkRdata: 1, rdata: 16'h8421});
        runXfer(1, 1'b1, 1'b0, 10'h011, 16'h0000, 2'b11, d, cl, wl, rl, bl, bb, rdv);
        e = sb.pop_front();
        nVectors++; if (d != e.latency || rl != e.rdLow) begin nMiscompares++; $display("[TB] FAIL t2_read_timing: got lat=%0d rd=%0d expected %0d %0d", d, rl, e.latency, e.rdLow); end
        nVectors++; if (rdv !== e.rdata) begin nMiscompares++; $display("[TB] FAIL t2_read_data: got %h expected %h", rdv, e.rdata); end
    endtask

    task automatic test_back_to_back();
        int d, cl, wl, rl, bl, bb;
        logic [15:0] rdv, val;
        logic [9:0] a;
        bit isWr;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            isWr = (i % 2 == 0);
            val = 16'($urandom);
            a = 10'($urandom);
            dIn = isWr ? ~val : val;
            sb.push_back('{latency: 6, csLow: 5, wrLow: isWr ? 3 : 0, rdLow: isWr ? 0 : 3, chkRdata: !isWr, rdata: val});
            runXfer(0, !isWr, isWr, a, val, 2'b11, d, cl, wl, rl, bl, bb, rdv);
            e = sb.pop_front();
            nVectors++;
            if (d != e.latency || cl != e.csLow || wl != e.wrLow || rl != e.rdLow || bb != 0) begin
                nMiscompares++;
                $display("[TB] FAIL b2b_%0d_timing: got lat=%0d cs=%0d wr=%0d rd=%0d bad=%0d expected %0d %0d %0d %0d 0",
                         i, d, cl, wl, rl, bb, e.latency, e.csLow, e.wrLow, e.rdLow);
            end
            if (e.chkRdata) begin
                nVectors++; if (rdv !== e.rdata) begin nMiscompares++; $display("[TB] FAIL b2b_%0d_data: got %h expected %h", i, rdv, e.rdata); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int d, cl, wl, rl, bl, bb, waitDrops, csDrops;
        logic [15:0] rdv;
        dIn = 16'hC3C3;
        runXfer(0, 1'b1, 1'b0, 10'h0AA, 16'h0000, 2'b11, d, cl, wl, rl, bl, bb, rdv);
        nVectors++; if (rdata0 !== 16'hC3C3) begin nMiscompares++; $display("[TB] FAIL pre_reset_data: got %h expected c3c3", rdata0); end
        cs0 = 1'b1; wr0 = 1'b1; rd0 = 1'b0; addr0 = 10'h2F0; wdata0 = 16'h7E7E; be0 = 2'b11;
        tick();
        tick();
        tick();
        nVectors++; if (wrN0 !== 1'b0 || oe0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL mid_strobe: got wr_n=%b oe=%b expected 0 1", wrN0, oe0); end
        RST_N = 1'b0;
        tick();
        nVectors++; if (csN0 !== 1'b1 || rdN0 !== 1'b1 || wrN0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL abort_strobes: got cs=%b rd=%b wr=%b expected 1 1 1", csN0, rdN0, wrN0); end
        nVectors++; if (oe0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_d_oe: got %b expected 0", oe0); end
        nVectors++; if (wait0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL abort_waitrequest: got %b expected 1", wait0); end
        nVectors++; if (rdata0 !== 16'd0 || wa0 !== 10'd0 || dout0 !== 16'd0) begin nMiscompares++; $display("[TB] FAIL abort_regs: got rd=%h a=%h d=%h expected 0 0 0", rdata0, wa0, dout0); end
        cs0 = 1'b0; wr0 = 1'b0;
        tick();
        RST_N = 1'b1;
        waitDrops = 0;
        csDrops = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (wait0 !== 1'b1) waitDrops++;
            if (csN0 !== 1'b1) csDrops++;
        end
        nVectors++; if (waitDrops != 0 || csDrops != 0) begin nMiscompares++; $display("[TB] FAIL abort_no_done: got wait_drops=%0d cs_drops=%0d expected 0 0", waitDrops, csDrops); end
    endtask

    task automatic test_irq();
        intN = 1'b1;
        tick();
        tick();
        tick();
        nVectors++; if (irq0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL irq_idle: got %b expected 0", irq0); end
        intN = 1'b0;
        #1;
`ifdef WIZ_INT_SYNC_EN
        nVectors++; if (irq0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL irq_sync_0: got %b expected 0", irq0); end
        tick();
        nVectors++; if (irq0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL irq_sync_1: got %b expected 0", irq0); end
        tick();
        nVectors++; if (irq0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL irq_sync_2: got %b expected 1", irq0); end
`else
        nVectors++; if (irq0 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL irq_comb_assert: got %b expected 1", irq0); end
        tick();
`endif
        intN = 1'b1;
        tick();
        tick();
        tick();
        nVectors++; if (irq0 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL irq_release: got %b expected 0", irq0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_skip();
        test_custom_timing();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule

// File: doc/wiz_bus_ctrl.md
WIZ_BUS_CTRL -- requirements
Module: wiz_bus_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles WIZ_CS_N/WIZ_A stable before strobe, legal 1..15.
REQ-002 SHALL have parameter STROBE_CYC, default 3: cycles WIZ_RD_N/WIZ_WR_N held low, legal 1..15.
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles WIZ_CS_N/WIZ_A/data held after strobe release, legal 1..15.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 CLK  in  1  system clock; all state changes on its rising edge.
REQ-006 RST_N  in  1  synchronous active-low reset.
REQ-007 avs_chipselect  in  1  Avalon-MM slave select.
REQ-008 avs_address  in  10  W5300 register address.
REQ-009 avs_read / avs_write  in  1 each  Avalon read and write requests.
REQ-010 avs_writedata  in  16  write data.
REQ-011 avs_byteenable  in  2  byte lanes.
REQ-012 avs_readdata  out  16  read data, valid in the completion cycle.
REQ-013 avs_waitrequest  out  1  high until the transfer completes.
REQ-014 WIZ_A  out  10  chip address.
REQ-015 WIZ_D_OUT  out  16 / WIZ_D_OE  out  1 / WIZ_D_IN  in  16  split data bus; tristate is resolved at top level.
REQ-016 WIZ_CS_N, WIZ_RD_N, WIZ_WR_N  out  1 each  active-low chip strobes.
REQ-017 WIZ_INT_N  in  1  chip interrupt, active low, asynchronous.
REQ-018 irq  out  1  active-high interrupt to the CPU.

Function
REQ-019 SHALL implement the FSM IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE, with a 4-bit down-counter for each timed phase.
REQ-020 In IDLE, a request (avs_chipselect & (avs_read | avs_write)) SHALL latch address, writedata and direction, then enter SETUP on the next edge.
REQ-021 If avs_read and avs_write are both high, the transfer SHALL be a write.
REQ-022 SETUP SHALL last SETUP_CYC cycles with WIZ_CS_N=0, WIZ_A valid, and WIZ_D_OE=1 for writes.
REQ-023 STROBE SHALL last STROBE_CYC cycles with WIZ_RD_N=0 (read) or WIZ_WR_N=0 (write).
REQ-024 On the last STROBE cycle of a read, WIZ_D_IN SHALL be registered into avs_readdata.
REQ-025 HOLD SHALL last HOLD_CYC cycles with RD_N=WR_N=1 and CS_N, A and D_OE unchanged.
REQ-026 DONE SHALL last 1 cycle with avs_waitrequest=0 and all chip strobes high; every other state SHALL drive avs_waitrequest=1.
REQ-027 Total latency from the accepting IDLE cycle to the DONE cycle SHALL be 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (6 at defaults).
REQ-028 avs_byteenable != 2'b11 SHALL skip chip access: IDLE -> DONE directly, no strobe asserted, avs_readdata=16'h0000.
REQ-029 Requests arriving outside IDLE SHALL be ignored until DONE; the master holds its signals per Avalon waitrequest rules.
REQ-030 WIZ_RD_N and WIZ_WR_N SHALL never be low simultaneously.
REQ-031 All chip-side outputs SHALL be registered (glitch-free).

Reset
REQ-032 RST_N=0 at an edge SHALL force IDLE; WIZ_CS_N=WIZ_RD_N=WIZ_WR_N=1; WIZ_D_OE=0; WIZ_A=0; WIZ_D_OUT=0; avs_readdata=0; avs_waitrequest=1; irq=0; synchronizer flops=1.
REQ-033 Reset mid-transfer SHALL abort the transfer on the next edge; no DONE cycle is generated.

Configuration
REQ-034 With WIZ_INT_SYNC_EN defined, WIZ_INT_N SHALL pass through a 2-flop synchronizer, and irq SHALL be the registered inverse (2-cycle latency, reset to 0).
REQ-035 Without WIZ_INT_SYNC_EN, irq SHALL be combinational !WIZ_INT_N, with no added flops.

Verification
REQ-036 Write addr 10'h200, data 16'hA55A, be=11, defaults -> CS_N low 5 cycles, WR_N low exactly 3, D_OE=1 with D_OUT=A55A throughout, waitrequest low on cycle 6 only.
REQ-037 Read addr 10'h004, WIZ_D_IN=16'h1234 -> RD_N low 3 cycles, readdata=1234 in DONE, WR_N stays high.
REQ-038 Write with be=01 -> no CS_N/WR_N activity, waitrequest low on 2nd cycle.
REQ-039 Reset asserted in the 2nd STROBE cycle of a write -> all strobes high and D_OE=0 the next cycle, no waitrequest drop.
REQ-040 Read and write both high, SETUP=2/STROBE=1/HOLD=2 -> write performed, total latency 6 cycles.
REQ-041 WIZ_INT_N falls -> irq=1 after 2 cycles with WIZ_INT_SYNC_EN, same cycle without it.
